alu_op_sequencer: RTL

Upstream issue stage for the team's 8-bit combinational ALU (A, B, 3-bit opcode -> 8-bit out).
- Buffers operand/opcode commands in a small FIFO and presents one command at a time to the ALU on registered outputs.
- Captures the ALU result one cycle later and offers it, with its opcode and a zero flag, on a valid/ready result port.
- Decouples the command producer from the result consumer; command order is preserved.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_cmd_fifo.sv | 52 +++++
 rtl/alu_op_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer states and command layout shared by the ALU issue stage
package alu_pkg;
  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;
  localparam int CMD_W = 19;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: power-of-two command FIFO with occupancy count and show-ahead head
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;
  // a full FIFO refuses pushes even when a pop frees a slot the same cycle
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end
  // storage, pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands, issues one at a time and returns results on valid/ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic [2:0]    cmd_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [7:0]    alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [2:0]    res_op,
  output logic          res_zero,
  output logic [CW-1:0] fifo_count
);
  cmd_t head;
  logic full, empty, pop;
  state_e state_q, state_d;
  logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [2:0] alu_op_q, alu_op_d, res_op_q, res_op_d;
  logic res_valid_q, res_valid_d, res_zero_q, res_zero_d;
  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .din   ({cmd_a, cmd_b, cmd_op}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  assign cmd_ready  = !full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign res_zero   = res_zero_q;
  // issue FSM: operands change only on a pop, result captured after one stable ISSUE cycle
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_zero_d  = res_zero_q;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        res_data_d  = alu_out;
        res_op_d    = alu_op_q;
        res_zero_d  = alu_out == 8'h00;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        pop         = !empty;
        state_d     = empty ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
    alu_a_d  = pop ? head.a : alu_a_q;
    alu_b_d  = pop ? head.b : alu_b_q;
    alu_op_d = pop ? head.op : alu_op_q;
  end
  // state, operand and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ZERO;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_zero_q  <= res_zero_d;
    end
  end
endmodule
